// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer: double-buffered NTS TX frame store streaming to the MAC; NTS_TX_MIN_FRAME_PAD_EN enables 60-byte min frame padding
module nts_tx_buffer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_wr_en,
  input  logic [63:0] i_wr_data,
  input  logic        i_wr_last,
  input  logic [7:0]  i_wr_last_valid,
  input  logic        i_wr_discard,
  output logic        o_wr_ready,
  output logic        o_error,
  output logic        o_tx_start,
  input  logic        i_tx_ack,
  output logic [7:0]  o_tx_data_valid,
  output logic [63:0] o_tx_data
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic [1:0] {B_EMPTY, B_WRITING, B_FULL, B_SENDING} buf_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} tx_t;
  buf_t                  bst_q [2];
  buf_t                  bst_d [2];
  logic [CW-1:0]         cnt_q [2];
  logic [CW-1:0]         cnt_d [2];
  logic [7:0]            mask_q [2];
  logic [7:0]            mask_d [2];
  logic                  bad_q [2];
  logic                  bad_d [2];
  logic                  wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  tx_t                   tx_q, tx_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [7:0]            vld_q, vld_d;
  logic                  err_q, err_d;
  logic [1:0][63:0]      rd_data;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_go, overrun, mask_ok, last, issue;
  logic [CW-1:0]         len, pos;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
  logic [7:0]            keep_q, keep_d;
  logic [63:0]           keep_w;
  logic                  short_f;
`endif

  assign o_wr_ready      = bst_q[wbuf_q] == B_EMPTY || bst_q[wbuf_q] == B_WRITING;
  assign o_error         = err_q;
  assign o_tx_start      = tx_q == S_REQ;
  assign o_tx_data_valid = vld_q;
  assign wr_go           = o_wr_ready && i_wr_en && !i_wr_discard;
  assign overrun         = cnt_q[wbuf_q] == CAP;
  assign mask_ok         = i_wr_last_valid != 8'h00 &&
                           (~i_wr_last_valid & (~i_wr_last_valid + 8'd1)) == 8'h00;
  assign pos             = tx_q == S_SEND ? idx_q : '0;
  assign rd_addr         = pos[ADDR_WIDTH-1:0];
  assign last            = pos == cnt_q[rbuf_q] - 1'b1;
  assign issue           = (tx_q == S_REQ && i_tx_ack) || (tx_q == S_SEND && idx_q < len);
`ifdef NTS_TX_MIN_FRAME_PAD_EN
  assign short_f   = cnt_q[rbuf_q] < CW'(8) || (cnt_q[rbuf_q] == CW'(8) && !mask_q[rbuf_q][4]);
  assign len       = short_f ? CW'(8) : cnt_q[rbuf_q];
  assign o_tx_data = rd_data[rbuf_q] & keep_w;
  for (genvar k = 0; k < 8; k++) begin : g_keep
    assign keep_w[8*k +: 8] = {8{keep_q[k]}};
  end
`else
  assign len       = cnt_q[rbuf_q];
  assign o_tx_data = vld_q != 8'h00 ? rd_data[rbuf_q] : '0;
`endif

  // Each bank has one port: the writer owns it while EMPTY/WRITING, the TX side while FULL/SENDING
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [63:0]           mem [2**ADDR_WIDTH];
    logic [63:0]           rd_q;
    logic [ADDR_WIDTH-1:0] addr;
    assign addr       = (bst_q[b] == B_FULL || bst_q[b] == B_SENDING) ? rd_addr : cnt_q[b][ADDR_WIDTH-1:0];
    assign rd_data[b] = rd_q;
    // Read-first single-port BRAM
    always_ff @(posedge i_clk) begin
      if (we[b]) mem[addr] <= i_wr_data;
      rd_q <= mem[addr];
    end
  end

  // Buffer bookkeeping for the write side and the TX state machine
  always_comb begin
    bst_d  = bst_q;
    cnt_d  = cnt_q;
    mask_d = mask_q;
    bad_d  = bad_q;
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    err_d  = 1'b0;
    we     = '0;
    tx_d   = tx_q;
    idx_d  = idx_q;
    vld_d  = '0;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
    keep_d = '0;
`endif
    if (o_wr_ready && i_wr_discard) begin
      bst_d[wbuf_q] = B_EMPTY;
      cnt_d[wbuf_q] = '0;
      bad_d[wbuf_q] = 1'b0;
    end else if (wr_go) begin
      we[wbuf_q]    = !overrun;
      cnt_d[wbuf_q] = overrun ? cnt_q[wbuf_q] : cnt_q[wbuf_q] + 1'b1;
      bad_d[wbuf_q] = bad_q[wbuf_q] || overrun;
      bst_d[wbuf_q] = B_WRITING;
      if (i_wr_last && (bad_d[wbuf_q] || !mask_ok)) begin
        bst_d[wbuf_q] = B_EMPTY;
        cnt_d[wbuf_q] = '0;
        bad_d[wbuf_q] = 1'b0;
        err_d         = 1'b1;
      end else if (i_wr_last) begin
        bst_d[wbuf_q]  = B_FULL;
        mask_d[wbuf_q] = i_wr_last_valid;
        wbuf_d         = !wbuf_q;
      end
    end
    if (issue) begin
      idx_d = pos + 1'b1;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
      vld_d  = short_f ? (pos == CW'(7) ? 8'hF0 : 8'hFF) : (last ? mask_q[rbuf_q] : 8'hFF);
      keep_d = !short_f ? 8'hFF : pos < cnt_q[rbuf_q] - 1'b1 ? 8'hFF : last ? mask_q[rbuf_q] : 8'h00;
`else
      vld_d = last ? mask_q[rbuf_q] : 8'hFF;
`endif
    end
    case (tx_q)
      S_IDLE: if (bst_q[rbuf_q] == B_FULL) begin
        tx_d          = S_REQ;
        bst_d[rbuf_q] = B_SENDING;
      end
      S_REQ: tx_d = i_tx_ack ? S_SEND : S_REQ;
      S_SEND: if (!issue) begin
        tx_d          = S_IDLE;
        bst_d[rbuf_q] = B_EMPTY;
        cnt_d[rbuf_q] = '0;
        rbuf_d        = !rbuf_q;
      end
      default: tx_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons both buffers and any frame in flight
  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      bst_q  <= '{default: B_EMPTY};
      cnt_q  <= '{default: '0};
      mask_q <= '{default: '0};
      bad_q  <= '{default: 1'b0};
      wbuf_q <= 1'b0;
      rbuf_q <= 1'b0;
      tx_q   <= S_IDLE;
      idx_q  <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
      keep_q <= '0;
`endif
    end else begin
      bst_q  <= bst_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      bad_q  <= bad_d;
      wbuf_q <= wbuf_d;
      rbuf_q <= rbuf_d;
      tx_q   <= tx_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
`ifdef NTS_TX_MIN_FRAME_PAD_EN
      keep_q <= keep_d;
`endif
    end
  end
endmodule

// File: tb/tb_nts_tx_buffer.sv
// tb_nts_tx_buffer: directed and randomized frames checked against a queue-based frame model
module tb_nts_tx_buffer;
  localparam int AW = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, wr_last = 1'b0, wr_discard = 1'b0, ack = 1'b0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic        o_wr_ready, o_error, o_tx_start;
  logic [7:0]  o_tx_data_valid;
  logic [63:0] o_tx_data;
  int checks = 0, failures = 0, exp_err = 0;
  int n_err = 0, n_vld = 0, n_nrdy = 0;
  int b_err, b_vld, b_nrdy, l0;
  logic [63:0] fw [32];
  int          fn;
  logic [7:0]  fm;
  logic [63:0] exp_d [$];
  logic [7:0]  exp_v [$];
  int          exp_len [$];
  logic [7:0]  legal_tab [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0]  bad_tab [4] = '{8'h00, 8'h40, 8'hA0, 8'h7F};

  always #5 clk = ~clk;

  nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_areset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_wr_last(wr_last),
    .i_wr_last_valid(wr_mask), .i_wr_discard(wr_discard), .o_wr_ready(o_wr_ready), .o_error(o_error),
    .o_tx_start(o_tx_start), .i_tx_ack(ack), .o_tx_data_valid(o_tx_data_valid), .o_tx_data(o_tx_data)
  );

  always @(negedge clk) begin
    if (!rst && o_error) n_err++;
    if (!rst && o_tx_data_valid != 8'h00) n_vld++;
    if (!rst && !o_wr_ready) n_nrdy++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit legal(input logic [7:0] m);
    foreach (legal_tab[i]) if (legal_tab[i] == m) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] bytes_of(input logic [7:0] m);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Expected wire image of the frame held in fw/fn/fm
  task automatic model();
    if (fn > 2**AW || !legal(fm)) begin
      exp_err++;
      return;
    end
`ifdef NTS_TX_MIN_FRAME_PAD_EN
    begin
      int nbytes;
      nbytes = (fn - 1) * 8 + $countones(fm);
      if (nbytes < 60) begin
        for (int i = 0; i < 8; i++) begin
          exp_d.push_back(i < fn - 1 ? fw[i] : i == fn - 1 ? fw[i] & bytes_of(fm) : 64'h0);
          exp_v.push_back(i == 7 ? 8'hF0 : 8'hFF);
        end
        exp_len.push_back(8);
        return;
      end
    end
`endif
    for (int i = 0; i < fn; i++) begin
      exp_d.push_back(fw[i]);
      exp_v.push_back(i == fn - 1 ? fm : 8'hFF);
    end
    exp_len.push_back(fn);
  endtask

  task automatic write_frame();
    for (int i = 0; i < fn; i++) begin
      wr_en = 1'b1; wr_data = fw[i]; wr_last = i == fn - 1; wr_mask = fm;
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0; wr_mask = '0;
    model();
  endtask

  task automatic rand_frame(input int n, input logic [7:0] m);
    fn = n;
    fm = m;
    for (int i = 0; i < n; i++) fw[i] = {$urandom, $urandom};
  endtask

  task automatic wait_start();
    for (int i = 0; i < 300 && o_tx_start !== 1'b1; i++) tick();
    chk("tx_start", 64'(o_tx_start), 64'(1'b1));
  endtask

  task automatic recv(input int hold, input bit chk_rdy);
    int n;
    wait_start();
    repeat (hold) tick();
    chk("start_held", 64'(o_tx_start), 64'(1'b1));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n = exp_len.pop_front();
    for (int k = 0; k < n; k++) begin
      chk("tx_valid", 64'(o_tx_data_valid), 64'(exp_v.pop_front()));
      chk("tx_data", o_tx_data, exp_d.pop_front());
      if (chk_rdy && k == n - 1) chk("ready_last_word", 64'(o_wr_ready), 64'(1'b0));
      tick();
    end
    chk("tx_valid_end", 64'(o_tx_data_valid), 64'(8'h00));
    chk("tx_data_end", o_tx_data, 64'h0);
    chk("start_gap", 64'(o_tx_start), 64'(1'b0));
    if (chk_rdy) chk("ready_back", 64'(o_wr_ready), 64'(1'b1));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", 64'(o_wr_ready), 64'(1'b1));
    chk("rst_error", 64'(o_error), 64'(1'b0));
    chk("rst_start", 64'(o_tx_start), 64'(1'b0));
    chk("rst_valid", 64'(o_tx_data_valid), 64'(8'h00));
    chk("rst_data", o_tx_data, 64'h0);
    rst = 1'b0;
    tick();
    // 3-word frame, start latency and stream
    rand_frame(3, 8'hC0);
    write_frame();
    chk("start_w1", 64'(o_tx_start), 64'(1'b0));
    tick();
    chk("start_w2", 64'(o_tx_start), 64'(1'b1));
    recv(0, 1'b0);
    // A then B back-to-back with delayed ack
    rand_frame(2, legal_tab[$urandom_range(0, 7)]);
    write_frame();
    rand_frame(4, legal_tab[$urandom_range(0, 7)]);
    write_frame();
    chk("ready_both_full", 64'(o_wr_ready), 64'(1'b0));
    recv(20, 1'b1);
    recv(0, 1'b0);
    // overrun: 17 words then last
    b_err = n_err; b_vld = n_vld; b_nrdy = n_nrdy;
    rand_frame(18, 8'hFF);
    write_frame();
    repeat (10) tick();
    chk("ovr_error", 64'(n_err - b_err), 64'(1));
    chk("ovr_no_tx", 64'(n_vld - b_vld), 64'(0));
    chk("ovr_ready", 64'(n_nrdy - b_nrdy), 64'(0));
    // discard then 1-word frame
    b_err = n_err; b_vld = n_vld;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = {$urandom, $urandom};
      tick();
    end
    wr_discard = 1'b1;
    tick();
    wr_discard = 1'b0; wr_en = 1'b0;
    fn = 1; fm = 8'h80; fw[0] = {8{8'hAA}};
    write_frame();
    l0 = exp_len[0];
    recv(0, 1'b0);
    chk("disc_words", 64'(n_vld - b_vld), 64'(l0));
    chk("disc_no_err", 64'(n_err - b_err), 64'(0));
    // reset during word 2 of a 5-word frame
    rand_frame(5, 8'hFF);
    write_frame();
    wait_start();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    tick();
    chk("mid_word2_valid", 64'(o_tx_data_valid), 64'(exp_v[2]));
    chk("mid_word2_data", o_tx_data, exp_d[2]);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(o_tx_data_valid), 64'(8'h00));
    chk("mid_rst_data", o_tx_data, 64'h0);
    chk("mid_rst_start", 64'(o_tx_start), 64'(1'b0));
    chk("mid_rst_error", 64'(o_error), 64'(1'b0));
    chk("mid_rst_ready", 64'(o_wr_ready), 64'(1'b1));
    rst = 1'b0;
    exp_d.delete(); exp_v.delete(); exp_len.delete();
    b_vld = n_vld;
    repeat (20) tick();
    chk("no_remnant", 64'(n_vld - b_vld), 64'(0));
    chk("no_restart", 64'(o_tx_start), 64'(1'b0));
    // illegal last-word masks
    b_err = n_err; b_vld = n_vld;
    rand_frame(2, 8'h00);
    write_frame();
    rand_frame(3, 8'hA0);
    write_frame();
    repeat (5) tick();
    chk("mask_errors", 64'(n_err - b_err), 64'(2));
    chk("mask_no_tx", 64'(n_vld - b_vld), 64'(0));
    // randomized pairs of frames
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 2; j++) begin
        rand_frame($urandom_range(0, 7) == 0 ? 17 : $urandom_range(1, 16),
                   $urandom_range(0, 7) == 0 ? bad_tab[$urandom_range(0, 3)] : legal_tab[$urandom_range(0, 7)]);
        write_frame();
      end
      while (exp_len.size() > 0) recv($urandom_range(0, 3), 1'b0);
    end
    repeat (3) tick();
    chk("error_total", 64'(n_err), 64'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nts_tx_buffer.md
# nts_tx_buffer

Transmit-side double-buffered frame store between the NTS response engine and the MAC TX interface. The engine streams a complete frame of 64-bit words into one of two BRAM buffers. A TX state machine streams finished frames to the MAC one word per cycle after a start/ack handshake. While one buffer drains to the MAC, the engine can fill the other.

## Interface

- ADDR_WIDTH, 10, word address width per buffer; capacity 2^ADDR_WIDTH words

- i_clk  in  1  clock
- i_areset  in  1  reset, synchronous active-high (sampled on rising i_clk)
- i_wr_en  in  1  write one word this cycle (honoured only when o_wr_ready=1)
- i_wr_data  in  64  frame word; data[63:56] is the first byte on the wire
- i_wr_last  in  1  qualifies i_wr_en: this word ends the frame
- i_wr_last_valid  in  8  byte mask of the last word; left-aligned (0x80,0xC0,…,0xFF)
- i_wr_discard  in  1  abort the frame being written
- o_wr_ready  out  1  a write buffer is available
- o_error  out  1  one-cycle pulse: frame dropped (overrun or illegal mask)
- o_tx_start  out  1  frame ready, request MAC
- i_tx_ack  in  1  MAC accepts; streaming begins the next cycle
- o_tx_data_valid  out  8  byte mask of o_tx_data; 0 when idle
- o_tx_data  out  64  frame word

## Operation

- Two buffers, each with a state: EMPTY, WRITING, FULL, SENDING. Each buffer also stores a word count (ADDR_WIDTH+1 bits) and a last-word mask.
- Write pointer `wbuf`; reset value 0.
- o_wr_ready=1 when buffer[wbuf] is EMPTY or WRITING.
- Write sequence:
  - i_wr_en stores the word at address counter[wbuf] and increments the counter.
  - The first word moves the buffer EMPTY→WRITING.
  - A word with i_wr_last moves the buffer WRITING→FULL (or EMPTY→FULL for a 1-word frame), latches the count and mask, and toggles wbuf.
- Overrun: a word arriving when counter = 2^ADDR_WIDTH is not written, and the frame is marked bad. On its i_wr_last the buffer returns to EMPTY, o_error pulses, and wbuf is not toggled.
- i_wr_last_valid = 0, or a non-left-aligned mask, on the last word drops the frame the same way as an overrun.
- i_wr_discard: buffer[wbuf] becomes EMPTY and its counter clears. No o_error pulse. Discard has priority over a simultaneous i_wr_en.
- TX FSM states: IDLE, REQ, SEND.
  - IDLE: if buffer[rbuf] is FULL, go to REQ and set that buffer to SENDING. `rbuf` resets to 0.
  - REQ: o_tx_start=1, held until i_tx_ack is sampled high, then go to SEND.
  - SEND: outputs words 0..N-1 on consecutive cycles with no gaps. o_tx_data_valid is 0xFF, except the last word, which uses the stored mask. After the last word the buffer becomes EMPTY, rbuf toggles, and the FSM returns to IDLE.
- Frames leave in write order, because rbuf and wbuf alternate.
- Each BRAM is single-port. Address mux: the write side owns the buffer in EMPTY/WRITING; the TX side owns it in FULL/SENDING. The two sides never touch the same buffer.
- i_wr_en while o_wr_ready=0 is ignored. It is not an error.

## Timing

- Reset values: o_wr_ready=1, o_error=0, o_tx_start=0, o_tx_data_valid=0, o_tx_data=0. Both buffers EMPTY, all counters 0, FSM IDLE.
- Reset mid-frame, on either side, abandons all buffer contents. Outputs reach their reset values the cycle after reset is sampled.
- Writing the last word at cycle w makes the buffer FULL at w+1. With TX idle, o_tx_start rises at w+2.
- i_tx_ack sampled at cycle t: word 0 appears at t+1 and word N-1 at t+N. o_tx_data_valid=0 at t+N+1.
- The next o_tx_start is no earlier than t+N+2.
- o_tx_data is 0 whenever o_tx_data_valid=0.
- Both buffers FULL: o_wr_ready=0 until the SENDING buffer empties. It returns to 1 the cycle after the last word is sent.

## Configuration

- NTS_TX_MIN_FRAME_PAD_EN defined: frames shorter than 60 bytes are zero-padded to exactly 60 bytes (7 words of 0xFF, last word 0xF0).
  - Bytes beyond the written mask in the last word are zero.
  - Padding words are generated, not read from BRAM.
  - SEND length is 8 words.
- Undefined: frames are transmitted exactly as written, with no padding logic.

## Test plan

- Write a 3-word frame, last mask 0xC0, ack held high:
  - o_tx_start at w+2.
  - Words at t+1..t+3 with masks FF, FF, C0.
  - o_tx_data_valid=0 at t+4.
- Write frames A (2 words) and B (4 words) back-to-back while delaying ack for 20 cycles:
  - o_wr_ready drops after B.
  - A is sent first, then B.
  - o_wr_ready returns the cycle after A's last word.
- ADDR_WIDTH=4, write 17 words then last: o_error pulses once, nothing is transmitted, o_wr_ready stays 1.
- Write 2 words, assert i_wr_discard, then write 1-word frame 0xAA…AA with mask 0x80: only the 1-word frame is transmitted, with mask 0x80.
- Assert i_areset during SEND word 2 of a 5-word frame: the next cycle all outputs are 0 and o_wr_ready=1. No remnant words appear afterwards.
- With NTS_TX_MIN_FRAME_PAD_EN, write a 2-word frame with mask 0xE0:
  - 8 words sent.
  - Word 1 has its lower 5 bytes zeroed.
  - Words 2–6 are 0 with mask FF; word 7 is 0 with mask F0.
